fgyrus_pcm_fetch: RTL
=====================

Name: fgyrus_pcm_fetch

Overview:
Sequencer on the fgyrus clock domain that drains one frame of PCM from the acortex-to-fgyrus PCM buffer after each ready pulse.
- Drives the buffer read address and absorbs the fixed memory read latency.
- Re-pairs the interleaved L/R words into stereo samples and presents them to the FFT front end with index and last markers.
- Counts frames and overruns, and exposes control and status on the local bus.

Parameters:
NUM_SAMPLES, 128, stereo samples per frame; the buffer holds 2*NUM_SAMPLES words.
MEM_RD_DELAY, 2, buffer read latency in cycles (address to data); minimum 1.
MEM_ADDR_W, $clog2(NUM_SAMPLES)+1, buffer word address width; derived, not to be overridden.
LB_DATA_W, 32, local bus data width.
LB_ADDR_W, 8, local bus address width.

Ports:
fgyrus_clk  in  1  sole clock
fgyrus_rst  in  1  asynchronous, active-high reset
pcm_rdy  in  1  single-cycle pulse: a new frame is complete in the buffer
pcm_addr  out  MEM_ADDR_W  buffer read address (registered)
pcm_rdata  in  32  buffer read data, valid MEM_RD_DELAY cycles after pcm_addr
sample_valid  out  1  stereo sample strobe
sample_lpcm  out  32  left sample
sample_rpcm  out  32  right sample
sample_idx  out  MEM_ADDR_W-1  sample index, 0..NUM_SAMPLES-1
sample_last  out  1  high with sample_valid when sample_idx==NUM_SAMPLES-1
frame_done  out  1  one-cycle pulse after the last sample
busy  out  1  high while a frame is being fetched
lb_wr_en  in  1  local bus write strobe
lb_rd_en  in  1  local bus read strobe
lb_addr  in  LB_ADDR_W  register address
lb_wr_data  in  LB_DATA_W  write data
lb_wr_valid  out  1  write acknowledge
lb_rd_valid  out  1  read acknowledge
lb_rd_data  out  LB_DATA_W  read data

Behaviour:
- Reset: all outputs 0, pcm_addr=0, FSM in IDLE, enable=0, all counters 0.
- Buffer layout: sample k has L at word 2k and R at word 2k+1.
- FSM states:
  - IDLE: on pcm_rdy & enable, go to FETCH and set busy=1 on that edge. pcm_rdy while enable=0 is ignored and not counted.
  - FETCH: pcm_addr steps 0,1,...,2*NUM_SAMPLES-1, one word per cycle. First address is on the cycle after pcm_rdy. After the last address, go to DRAIN.
  - DRAIN: wait for the in-flight reads (MEM_RD_DELAY+1 cycles), then go to DONE.
  - DONE: frame_done=1 for one cycle, frame_cnt+1 (16-bit, wraps), busy=0, return to IDLE.
- Read pipeline:
  - MEM_RD_DELAY-deep shift register carries {issue, addr[0], addr>>1}.
  - Delayed issue with addr[0]=0: capture pcm_rdata into the L hold register.
  - Delayed issue with addr[0]=1: on the next edge, assert sample_valid for one cycle with sample_lpcm=L hold, sample_rpcm=pcm_rdata, sample_idx=addr>>1.
  - Sample outputs hold their values between strobes.
- Timing, pcm_rdy at cycle 0 (MEM_RD_DELAY=2):
  - pair k valid at cycle 2k+5, so pair 0 at cycle 5 and pair 127 at cycle 259.
  - frame_done and busy falling at cycle 260.
  - General formula: 2k+3+MEM_RD_DELAY.
- No backpressure: the consumer must accept one sample every two cycles.
- Overrun: pcm_rdy in FETCH, DRAIN or DONE increments overrun_cnt (8-bit, saturates at 255). The pulse is dropped and the current frame continues undisturbed.
- Clearing enable mid-frame: the current frame completes; only new frames are inhibited.
- Registers:
  - 0x00 CONTROL, R/W. Bit0 enable. Bit1 clr_ovr: write-1 self-clearing, always reads 0. clr_ovr wins over a coincident overrun event.
  - 0x01 STATUS, RO. Bit0 busy, [15:8] overrun_cnt, [31:16] frame_cnt.
  - Unmapped read returns 0xdeadbabe; unmapped writes are ignored.
- Bus timing: lb_wr_valid and lb_rd_valid follow lb_wr_en and lb_rd_en by one cycle; lb_rd_data is registered with the same latency.
- Reset asserted mid-frame: immediate return to reset values; no frame_done is emitted.

Test Plan:
1. Buffer model preloaded with word n = 0xA000_0000+n, enable=1, pcm_rdy at cycle 0 -> 128 sample_valid strobes; sample k has L=0xA000_0000+2k and R=0xA000_0000+2k+1. First strobe at cycle 5, sample_last at cycle 259 with idx=127, frame_done at cycle 260.
2. enable=0, then pcm_rdy -> no pcm_addr activity, busy stays 0, STATUS reads 0x0000_0000.
3. Second pcm_rdy at cycle 100 of a frame -> frame output unchanged; STATUS overrun_cnt=1 and frame_cnt=1 after DONE.
4. 300 overrun pulses -> overrun_cnt=255. Write CONTROL=0x3 -> overrun_cnt=0 and enable stays 1. Overrun on the same cycle as the clear -> count stays 0.
5. Clear enable at cycle 50 of a frame -> all 128 samples delivered; a later pcm_rdy is ignored.
6. fgyrus_rst pulsed at cycle 60 of a frame -> outputs 0 and busy=0; the next pcm_rdy (after re-enabling) starts a full frame at address 0. Read of 0x55 -> 0xdeadbabe with lb_rd_valid one cycle after lb_rd_en.

Source files
------------

// File: rtl/fgyrus_pcm_fetch.sv
// Drains one frame of interleaved L/R PCM words from the acortex-to-fgyrus buffer
// per ready pulse, re-pairs them into stereo samples and exposes control/status.
module fgyrus_pcm_fetch #(
  parameter int NUM_SAMPLES  = 128,
  parameter int MEM_RD_DELAY = 2,
  parameter int MEM_ADDR_W   = $clog2(NUM_SAMPLES) + 1,
  parameter int LB_DATA_W    = 32,
  parameter int LB_ADDR_W    = 8
) (
  input  logic                  fgyrus_clk,
  input  logic                  fgyrus_rst,
  input  logic                  pcm_rdy,
  output logic [MEM_ADDR_W-1:0] pcm_addr,
  input  logic [31:0]           pcm_rdata,
  output logic                  sample_valid,
  output logic [31:0]           sample_lpcm,
  output logic [31:0]           sample_rpcm,
  output logic [MEM_ADDR_W-2:0] sample_idx,
  output logic                  sample_last,
  output logic                  frame_done,
  output logic                  busy,
  input  logic                  lb_wr_en,
  input  logic                  lb_rd_en,
  input  logic [LB_ADDR_W-1:0]  lb_addr,
  input  logic [LB_DATA_W-1:0]  lb_wr_data,
  output logic                  lb_wr_valid,
  output logic                  lb_rd_valid,
  output logic [LB_DATA_W-1:0]  lb_rd_data
);

  localparam int DRAIN_W = $clog2(MEM_RD_DELAY + 1) + 1;
  localparam logic [MEM_ADDR_W-1:0] LAST_ADDR  = MEM_ADDR_W'(2 * NUM_SAMPLES - 1);
  localparam logic [MEM_ADDR_W-2:0] IDX_LAST   = (MEM_ADDR_W - 1)'(NUM_SAMPLES - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(MEM_RD_DELAY);
  localparam logic [LB_ADDR_W-1:0]  ADDR_CTRL  = LB_ADDR_W'(0);
  localparam logic [LB_ADDR_W-1:0]  ADDR_STAT  = LB_ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;

  logic                    iss_pipe_q [MEM_RD_DELAY];
  logic                    odd_pipe_q [MEM_RD_DELAY];
  logic [MEM_ADDR_W-2:0]   idx_pipe_q [MEM_RD_DELAY];

  logic [31:0]             lhold_q;
  logic                    smp_valid_q, smp_last_q;
  logic [31:0]             smp_l_q, smp_r_q;
  logic [MEM_ADDR_W-2:0]   smp_idx_q;

  logic                    enable_q, enable_d;
  logic [7:0]              ovr_q, ovr_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    wr_valid_q, rd_valid_q;
  logic [LB_DATA_W-1:0]    rd_data_q, rd_data_d;

  logic                    busy_w, overrun_evt, wr_ctrl;
  logic                    dly_iss, dly_odd;
  logic [MEM_ADDR_W-2:0]   dly_idx;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (pcm_rdy && enable_q) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + MEM_ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + DRAIN_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  assign busy_w      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign overrun_evt = pcm_rdy && (state_q != S_IDLE);

  // Issue tag travels alongside the read so the pairing logic sees it exactly
  // when the corresponding word appears on pcm_rdata.
  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst) begin
      for (int unsigned i = 0; i < unsigned'(MEM_RD_DELAY); i++) begin
        iss_pipe_q[i] <= 1'b0;
        odd_pipe_q[i] <= 1'b0;
        idx_pipe_q[i] <= '0;
      end
    end else begin
      iss_pipe_q[0] <= (state_q == S_FETCH);
      odd_pipe_q[0] <= addr_q[0];
      idx_pipe_q[0] <= addr_q[MEM_ADDR_W-1:1];
      for (int unsigned i = 1; i < unsigned'(MEM_RD_DELAY); i++) begin
        iss_pipe_q[i] <= iss_pipe_q[i-1];
        odd_pipe_q[i] <= odd_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

  assign dly_iss = iss_pipe_q[MEM_RD_DELAY-1];
  assign dly_odd = odd_pipe_q[MEM_RD_DELAY-1];
  assign dly_idx = idx_pipe_q[MEM_RD_DELAY-1];

  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst) begin
      lhold_q     <= '0;
      smp_valid_q <= 1'b0;
      smp_last_q  <= 1'b0;
      smp_l_q     <= '0;
      smp_r_q     <= '0;
      smp_idx_q   <= '0;
    end else begin
      smp_valid_q <= dly_iss && dly_odd;
      smp_last_q  <= dly_iss && dly_odd && (dly_idx == IDX_LAST);
      if (dly_iss && !dly_odd) lhold_q <= pcm_rdata;
      if (dly_iss && dly_odd) begin
        smp_l_q   <= lhold_q;
        smp_r_q   <= pcm_rdata;
        smp_idx_q <= dly_idx;
      end
    end
  end

  assign wr_ctrl = lb_wr_en && (lb_addr == ADDR_CTRL);

  always_comb begin
    enable_d    = enable_q;
    ovr_d       = ovr_q;
    frame_cnt_d = frame_cnt_q;
    if (wr_ctrl) enable_d = lb_wr_data[0];
    // Clear takes priority over an overrun landing on the same cycle.
    if (wr_ctrl && lb_wr_data[1])    ovr_d = '0;
    else if (overrun_evt && ovr_q != '1) ovr_d = ovr_q + 8'd1;
    if (state_q == S_DONE) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (lb_rd_en) begin
      case (lb_addr)
        ADDR_CTRL: begin
          rd_data_d    = '0;
          rd_data_d[0] = enable_q;
        end
        ADDR_STAT: rd_data_d = LB_DATA_W'({frame_cnt_q, ovr_q, 7'd0, busy_w});
        default:   rd_data_d = LB_DATA_W'(32'hdeadbabe);
      endcase
    end
  end

  always_ff @(posedge fgyrus_clk or posedge fgyrus_rst) begin
    if (fgyrus_rst) begin
      enable_q    <= 1'b0;
      ovr_q       <= '0;
      frame_cnt_q <= '0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      enable_q    <= enable_d;
      ovr_q       <= ovr_d;
      frame_cnt_q <= frame_cnt_d;
      wr_valid_q  <= lb_wr_en;
      rd_valid_q  <= lb_rd_en;
      rd_data_q   <= rd_data_d;
    end
  end

  assign pcm_addr     = addr_q;
  assign sample_valid = smp_valid_q;
  assign sample_lpcm  = smp_l_q;
  assign sample_rpcm  = smp_r_q;
  assign sample_idx   = smp_idx_q;
  assign sample_last  = smp_last_q;
  assign frame_done   = (state_q == S_DONE);
  assign busy         = busy_w;
  assign lb_wr_valid  = wr_valid_q;
  assign lb_rd_valid  = rd_valid_q;
  assign lb_rd_data   = rd_data_q;

endmodule
